lut_m_ctrl: RTL and testbench
=============================

# lut_m_ctrl

Controller that sits in front of a memory LUT (`lut_m`) and turns it into a shared small RAM. It assembles bulk configuration words into a full `MEM_SIZE` image and commits it with a single `cen` pulse. It round-robin arbitrates two single-bit write requesters onto the LUT's one write port. Because the LUT shares one address for read and write, it also muxes the LUT address between the read port and the granted writer.

## Interface
Parameters:
- `INPUTS`, 4, LUT address width.
- `MEM_SIZE`, 2**INPUTS, LUT bit count.
- `CONFIG_WIDTH`, 4, bulk config word width. `MEM_SIZE` is an integer multiple of `CONFIG_WIDTH`. `WORDS = MEM_SIZE/CONFIG_WIDTH`.

Ports:
- `cclk` in 1: the single clock for this block and the LUT.
- `rst_n` in 1: asynchronous, active-low reset.
- `cfg_data` in CONFIG_WIDTH: bulk config word.
- `cfg_valid` in 1, `cfg_ready` out 1: config word handshake.
- `cfg_done` out 1: one-cycle pulse, asserted in the commit cycle.
- `wr0_addr` in INPUTS, `wr0_data` in 1, `wr0_valid` in 1, `wr0_ready` out 1: requester 0.
- `wr1_addr` in INPUTS, `wr1_data` in 1, `wr1_valid` in 1, `wr1_ready` out 1: requester 1.
- `rd_addr` in INPUTS: read address.
- `rd_data` out 1: read data, passthrough of `lut_out`.
- `rd_valid` out 1: `rd_data` reflects `rd_addr` this cycle.
- `lut_addr` out INPUTS: LUT address.
- `lut_out` in 1: LUT read data.
- `lut_cen` out 1: LUT config enable.
- `lut_config` out MEM_SIZE: LUT config image.
- `lut_data_in` out 1: LUT write data.
- `lut_write_en` out 1: LUT write enable.
- `busy` out 1: high whenever state is not IDLE.

## Operation
- States: IDLE, LOAD, COMMIT, WRITE.
- Transfers complete on any rising `cclk` edge where valid and ready are both high.
- `cfg_ready` = 1 in IDLE and LOAD, 0 otherwise.
- Config has priority over writes in IDLE. In IDLE with `cfg_valid`=1, both `wrN_ready` are 0.
- Config word order: word k goes to shadow bits [k*CONFIG_WIDTH +: CONFIG_WIDTH]. Word 0 is the LSBs.
- Word counter width is clog2(WORDS)+1. It clears to 0 on entry to COMMIT.
- IDLE transitions:
  - Config word accepted with WORDS>1 -> LOAD, count=1.
  - Config word accepted with WORDS==1 -> COMMIT.
  - Otherwise a write granted -> WRITE.
  - Otherwise stay in IDLE.
- LOAD:
  - Accepts words.
  - On acceptance of word WORDS-1 -> COMMIT.
  - Writes are never granted in LOAD.
- COMMIT lasts exactly one cycle, then -> IDLE. In that cycle:
  - `lut_config` = shadow.
  - `lut_cen`=1 and `cfg_done`=1.
- Arbitration runs in IDLE (when `cfg_valid`=0) and in WRITE (when `cfg_valid`=0):
  - If only one requester is valid, grant it.
  - If both are valid, grant the one not granted last.
  - The grant sets `wrN_ready`=1 combinationally for that requester only.
  - `last_grant` updates on acceptance.
  - `last_grant` resets to 1, so requester 0 wins the first tie.
- Accepted `addr`/`data` are latched into registers. The next cycle is WRITE, with:
  - `lut_addr` = latched addr.
  - `lut_data_in` = latched data.
  - `lut_write_en`=1.
- WRITE transitions:
  - A new write accepted in the same cycle -> WRITE again, giving back-to-back writes at 1 per cycle.
  - Otherwise -> IDLE.
  - `cfg_valid` high in WRITE blocks new grants, so the config is accepted in the following IDLE.
- `lut_addr` = `rd_addr` in IDLE, LOAD and COMMIT.
- `rd_valid` = 1 in IDLE and LOAD, 0 in COMMIT and WRITE.

## Timing
- Reset (async assert, sync release). All registers clear:
  - State = IDLE, count=0, shadow=0, `last_grant`=1.
  - `lut_config`=0, `lut_cen`=0, `lut_write_en`=0, `lut_data_in`=0.
  - `cfg_done`=0, `busy`=0.
  - After reset, `cfg_ready`=1 and `rd_valid`=1.
- `lut_cen`, `lut_write_en`, `lut_data_in`, `lut_config` and `cfg_done` are register outputs.
- Config latency: last word accepted at edge t -> `lut_cen` and `cfg_done` high for the cycle t..t+1. `cfg_ready` is 0 in that cycle.
- Write latency: accepted at edge t -> `lut_write_en` high for the cycle t..t+1. New data is readable from edge t+1 onward.
- Reset mid-LOAD discards the partial image. No `lut_cen` pulse is produced.
- Reset mid-WRITE drops the write. `lut_write_en` falls immediately (async).
- A requester dropping valid before acceptance is legal; no write occurs.
- The bus never has `lut_cen` and `lut_write_en` high in the same cycle.

## Test plan
- Reset, then 4 words 0x1,0x2,0x3,0x4 (INPUTS=4, CONFIG_WIDTH=4) -> exactly one `lut_cen` pulse with `lut_config`=16'h4321 and `cfg_done` coincident. Reads then return the matching bits, e.g. `rd_addr`=0 -> 1, `rd_addr`=4 -> 0.
- `wr0` and `wr1` both valid continuously, addrs 3/5, data 1/1 -> grants alternate 0,1,0,1. `lut_write_en` stays high every cycle. `rd_valid`=0 throughout. Afterwards, reads of 3 and 5 return 1.
- `cfg_valid` asserted while `wr0_valid` is pending in IDLE -> config is taken first, `wr0_ready` stays 0 through LOAD and COMMIT, and `wr0` is written in the cycle after COMMIT.
- `cfg_valid` asserted during a WRITE stream -> the current write completes, no new grant is made, and IDLE accepts the config word next.
- `rst_n` pulsed after 2 of 4 words -> no `lut_cen`. A fresh 4-word load then commits the full new image only.
- `wr1_valid` raised and dropped before a grant while `wr0` is being served -> no write to the `wr1` address.

Source files
------------

// File: rtl/lut_m_ctrl.sv
// Front-end controller for a single-port memory LUT: bulk image load with one-cycle
// commit, round-robin arbitration of two bit-write requesters, and shared address mux.
//
// state  | meaning
// IDLE   | read port owns the LUT address; accepts config (priority) or a write grant
// LOAD   | collecting config words into the shadow image; writes are held off
// COMMIT | one cycle: lut_cen pulses with the completed shadow image on lut_config
// WRITE  | latched write drives the LUT; a further write may be granted back-to-back
module lut_m_ctrl #(
    parameter int INPUTS       = 4,
    parameter int MEM_SIZE     = 2**INPUTS,
    parameter int CONFIG_WIDTH = 4
) (
    input  logic                    cclk,
    input  logic                    rst_n,
    input  logic [CONFIG_WIDTH-1:0] cfg_data,
    input  logic                    cfg_valid,
    output logic                    cfg_ready,
    output logic                    cfg_done,
    input  logic [INPUTS-1:0]       wr0_addr,
    input  logic                    wr0_data,
    input  logic                    wr0_valid,
    output logic                    wr0_ready,
    input  logic [INPUTS-1:0]       wr1_addr,
    input  logic                    wr1_data,
    input  logic                    wr1_valid,
    output logic                    wr1_ready,
    input  logic [INPUTS-1:0]       rd_addr,
    output logic                    rd_data,
    output logic                    rd_valid,
    output logic [INPUTS-1:0]       lut_addr,
    input  logic                    lut_out,
    output logic                    lut_cen,
    output logic [MEM_SIZE-1:0]     lut_config,
    output logic                    lut_data_in,
    output logic                    lut_write_en,
    output logic                    busy
);

    localparam int WORDS = MEM_SIZE / CONFIG_WIDTH;
    localparam int CNT_W = $clog2(WORDS) + 1;

    typedef enum logic [1:0] {IDLE, LOAD, COMMIT, WRITE} state_t;

    state_t              state, state_nxt;
    logic [CNT_W-1:0]    count, count_nxt;
    logic [MEM_SIZE-1:0] shadow, shadow_nxt;
    logic [INPUTS-1:0]   wr_addr_q;
    logic                last_grant;
    logic                arb_en, wr_req, sel, wr_accept, cfg_accept;

    // Grant selection: a lone requester wins; on a tie the one not served last wins.
    always_comb begin
        arb_en     = ((state == IDLE) || (state == WRITE)) && !cfg_valid;
        wr_req     = wr0_valid || wr1_valid;
        sel        = (wr0_valid && wr1_valid) ? ~last_grant : wr1_valid;
        wr0_ready  = arb_en && wr_req && !sel;
        wr1_ready  = arb_en && wr_req && sel;
        wr_accept  = arb_en && wr_req;
        cfg_ready  = (state == IDLE) || (state == LOAD);
        cfg_accept = cfg_valid && cfg_ready;
    end

    always_comb begin
        shadow_nxt = shadow;
        if (cfg_accept) begin
            for (int k = 0; k < WORDS; k++) begin
                if (count == CNT_W'(k))
                    shadow_nxt[k*CONFIG_WIDTH +: CONFIG_WIDTH] = cfg_data;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        count_nxt = count;
        case (state)
            IDLE: begin
                if (cfg_accept) begin
                    if (WORDS > 1) begin
                        state_nxt = LOAD;
                        count_nxt = CNT_W'(1);
                    end else begin
                        state_nxt = COMMIT;
                        count_nxt = '0;
                    end
                end else if (wr_accept) begin
                    state_nxt = WRITE;
                end
            end
            LOAD: begin
                if (cfg_accept) begin
                    if (count == CNT_W'(WORDS - 1)) begin
                        state_nxt = COMMIT;
                        count_nxt = '0;
                    end else begin
                        count_nxt = count + CNT_W'(1);
                    end
                end
            end
            COMMIT: begin
                state_nxt = IDLE;
                count_nxt = '0;
            end
            WRITE: begin
                state_nxt = wr_accept ? WRITE : IDLE;
            end
            default: begin
                state_nxt = IDLE;
                count_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge cclk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            count        <= '0;
            shadow       <= '0;
            last_grant   <= 1'b1;
            wr_addr_q    <= '0;
            lut_config   <= '0;
            lut_cen      <= 1'b0;
            cfg_done     <= 1'b0;
            lut_write_en <= 1'b0;
            lut_data_in  <= 1'b0;
        end else begin
            state        <= state_nxt;
            count        <= count_nxt;
            shadow       <= shadow_nxt;
            lut_cen      <= (state_nxt == COMMIT);
            cfg_done     <= (state_nxt == COMMIT);
            lut_write_en <= wr_accept;
            if (state_nxt == COMMIT)
                lut_config <= shadow_nxt;
            if (wr_accept) begin
                last_grant  <= sel;
                wr_addr_q   <= sel ? wr1_addr : wr0_addr;
                lut_data_in <= sel ? wr1_data : wr0_data;
            end
        end
    end

    // LUT has one shared address: the latched write address owns it only in WRITE.
    assign lut_addr = (state == WRITE) ? wr_addr_q : rd_addr;
    assign rd_data  = lut_out;
    assign rd_valid = (state == IDLE) || (state == LOAD);
    assign busy     = (state != IDLE);

endmodule

// File: tb/tb_lut_m_ctrl.sv
// Scoreboard bench for lut_m_ctrl with a behavioural LUT model behind it.
module tb_lut_m_ctrl;

    localparam int INPUTS = 4;
    localparam int MEM    = 16;
    localparam int CW     = 4;

    logic              cclk = 1'b0;
    logic              rst_n = 1'b0;
    logic [CW-1:0]     cfg_data = '0;
    logic              cfg_valid = 1'b0;
    logic              cfg_ready, cfg_done;
    logic [INPUTS-1:0] wr0_addr = '0, wr1_addr = '0, rd_addr = '0;
    logic              wr0_data = 1'b0, wr0_valid = 1'b0, wr0_ready;
    logic              wr1_data = 1'b0, wr1_valid = 1'b0, wr1_ready;
    logic              rd_data, rd_valid;
    logic [INPUTS-1:0] lut_addr;
    logic              lut_out, lut_cen, lut_data_in, lut_write_en, busy;
    logic [MEM-1:0]    lut_config;

    logic [MEM-1:0]    mem = '0;
    logic [MEM-1:0]    cfg_q[$];
    logic [INPUTS:0]   wr_q[$];
    logic              watch_blk = 1'b0;
    int                n_checks = 0;
    int                n_errors = 0;

    lut_m_ctrl #(.INPUTS(INPUTS), .MEM_SIZE(MEM), .CONFIG_WIDTH(CW)) dut (
        .cclk(cclk), .rst_n(rst_n),
        .cfg_data(cfg_data), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_done(cfg_done),
        .wr0_addr(wr0_addr), .wr0_data(wr0_data), .wr0_valid(wr0_valid), .wr0_ready(wr0_ready),
        .wr1_addr(wr1_addr), .wr1_data(wr1_data), .wr1_valid(wr1_valid), .wr1_ready(wr1_ready),
        .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
        .lut_addr(lut_addr), .lut_out(lut_out), .lut_cen(lut_cen), .lut_config(lut_config),
        .lut_data_in(lut_data_in), .lut_write_en(lut_write_en), .busy(busy)
    );

    always #5 cclk = ~cclk;

    // Behavioural LUT: config image load, single-bit write, combinational read.
    always @(posedge cclk) begin
        if (lut_cen)
            mem <= lut_config;
        else if (lut_write_en)
            mem[lut_addr] <= lut_data_in;
    end
    assign lut_out = mem[lut_addr];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    always @(negedge cclk) begin
        if (rst_n === 1'b1) begin
            if (lut_cen) begin
                if (cfg_q.size() == 0) begin
                    check("cen_unexpected", 32'(lut_config), 32'hFFFF_FFFF);
                end else begin
                    check("cfg_image", 32'(lut_config), 32'(cfg_q.pop_front()));
                    check("cfg_done", 32'(cfg_done), 32'd1);
                    check("cfg_ready_commit", 32'(cfg_ready), 32'd0);
                    check("cen_we_excl", 32'(lut_write_en), 32'd0);
                end
            end
            if (lut_write_en) begin
                if (wr_q.size() == 0)
                    check("we_unexpected", 32'({lut_addr, lut_data_in}), 32'hFFFF_FFFF);
                else
                    check("write_op", 32'({lut_addr, lut_data_in}), 32'(wr_q.pop_front()));
                check("rd_valid_write", 32'(rd_valid), 32'd0);
            end
            if (watch_blk)
                check("wr0_blocked", 32'(wr0_ready), 32'd0);
        end
    end

    task automatic step();
        @(posedge cclk);
        #1;
    endtask

    task automatic send_cfg(input logic [CW-1:0] w);
        int t;
        cfg_data  = w;
        cfg_valid = 1'b1;
        t = 0;
        do begin
            @(negedge cclk);
            t++;
        end while (!cfg_ready && t < 20);
        check("cfg_ready_wait", 32'(cfg_ready), 32'd1);
        step();
    endtask

    task automatic rd_check(input logic [INPUTS-1:0] a, input logic exp);
        rd_addr = a;
        @(negedge cclk);
        check("rd_valid", 32'(rd_valid), 32'd1);
        check($sformatf("rd_data[%0d]", a), 32'(rd_data), 32'(exp));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge cclk);
        #1 rst_n = 1'b1;
        @(negedge cclk);
        check("rst_cen", 32'(lut_cen), 32'd0);
        check("rst_we", 32'(lut_write_en), 32'd0);
        check("rst_din", 32'(lut_data_in), 32'd0);
        check("rst_cfg", 32'(lut_config), 32'd0);
        check("rst_done", 32'(cfg_done), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_cfg_ready", 32'(cfg_ready), 32'd1);
        check("rst_rd_valid", 32'(rd_valid), 32'd1);
        step();

        // Bulk load 1,2,3,4 -> 16'h4321
        cfg_q.push_back(16'h4321);
        send_cfg(4'h1); send_cfg(4'h2); send_cfg(4'h3); send_cfg(4'h4);
        cfg_valid = 1'b0;
        repeat (3) step();
        rd_check(4'd0, 1'b1); rd_check(4'd4, 1'b0); rd_check(4'd8, 1'b1);
        rd_check(4'd12, 1'b0); rd_check(4'd14, 1'b1);
        step();

        // Both requesters valid continuously: grants alternate 0,1,0,1
        wr0_addr = 4'd3; wr0_data = 1'b1; wr1_addr = 4'd5; wr1_data = 1'b1;
        for (int i = 0; i < 4; i++) wr_q.push_back((i % 2 == 0) ? {4'd3, 1'b1} : {4'd5, 1'b1});
        wr0_valid = 1'b1; wr1_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge cclk);
            check("grant0", 32'(wr0_ready), 32'(i % 2 == 0));
            check("grant1", 32'(wr1_ready), 32'(i % 2 == 1));
            step();
        end
        wr0_valid = 1'b0; wr1_valid = 1'b0;
        repeat (3) step();
        rd_check(4'd3, 1'b1); rd_check(4'd5, 1'b1);
        step();

        // Config takes priority over a pending wr0 in IDLE
        wr0_addr = 4'd7; wr0_data = 1'b1;
        cfg_q.push_back(16'h0000);
        wr_q.push_back({4'd7, 1'b1});
        wr0_valid = 1'b1; watch_blk = 1'b1;
        send_cfg(4'h0); send_cfg(4'h0); send_cfg(4'h0); send_cfg(4'h0);
        cfg_valid = 1'b0;
        @(negedge cclk);
        check("wr0_commit", 32'(wr0_ready), 32'd0);
        watch_blk = 1'b0;
        @(negedge cclk);
        check("wr0_after_commit", 32'(wr0_ready), 32'd1);
        step();
        wr0_valid = 1'b0;
        repeat (3) step();
        rd_check(4'd7, 1'b1); rd_check(4'd6, 1'b0);
        step();

        // cfg_valid raised during a write stream
        wr0_addr = 4'd10; wr0_data = 1'b1;
        repeat (3) wr_q.push_back({4'd10, 1'b1});
        cfg_q.push_back(16'hCDEF);
        wr0_valid = 1'b1;
        step(); step();
        cfg_data = 4'hF; cfg_valid = 1'b1;
        @(negedge cclk);
        check("stream_no_grant", 32'(wr0_ready), 32'd0);
        check("stream_cfg_ready", 32'(cfg_ready), 32'd0);
        check("stream_busy", 32'(busy), 32'd1);
        send_cfg(4'hF); send_cfg(4'hE); send_cfg(4'hD); send_cfg(4'hC);
        cfg_valid = 1'b0;
        @(negedge cclk);
        @(negedge cclk);
        check("stream_regrant", 32'(wr0_ready), 32'd1);
        step();
        wr0_valid = 1'b0;
        repeat (3) step();
        rd_check(4'd0, 1'b1); rd_check(4'd4, 1'b0); rd_check(4'd10, 1'b1); rd_check(4'd13, 1'b0);
        step();

        // Reset after 2 of 4 words, then reset mid-write
        send_cfg(4'hA); send_cfg(4'hB);
        cfg_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check("rst_load_busy", 32'(busy), 32'd0);
        check("rst_load_cfg", 32'(lut_config), 32'd0);
        step();
        rst_n = 1'b1;
        repeat (4) step();
        wr0_addr = 4'd2; wr0_data = 1'b1; wr0_valid = 1'b1;
        step();
        check("midwr_we", 32'(lut_write_en), 32'd1);
        #1 rst_n = 1'b0; wr0_valid = 1'b0;
        #1;
        check("rst_write_we", 32'(lut_write_en), 32'd0);
        check("rst_write_din", 32'(lut_data_in), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        cfg_q.push_back(16'h8765);
        send_cfg(4'h5); send_cfg(4'h6); send_cfg(4'h7); send_cfg(4'h8);
        cfg_valid = 1'b0;
        repeat (3) step();
        rd_check(4'd0, 1'b1); rd_check(4'd1, 1'b0); rd_check(4'd2, 1'b1);
        rd_check(4'd4, 1'b0); rd_check(4'd15, 1'b1);
        step();

        // wr1 pulses within a cycle while wr0 is served: never granted at an edge
        wr0_addr = 4'd1; wr0_data = 1'b1; wr1_addr = 4'd12; wr1_data = 1'b1;
        repeat (3) wr_q.push_back({4'd1, 1'b1});
        wr0_valid = 1'b1;
        step();
        wr1_valid = 1'b1;
        #3 wr1_valid = 1'b0;
        step(); step();
        wr0_valid = 1'b0;
        repeat (3) step();
        rd_check(4'd1, 1'b1); rd_check(4'd12, 1'b0);
        step();

        check("cfg_pending", 32'(cfg_q.size()), 32'd0);
        check("wr_pending", 32'(wr_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
